mmio_uart_tx: RTL

Memory-mapped UART transmitter on the CPU data bus, in parallel with RAM. It decodes CPU stores into a TX FIFO and serialises bytes as 8N1 on a pin. It returns a status word on CPU loads, using the same one-cycle read latency as RAM. The top-level read mux uses sel_q to choose between this block and RAM.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/mmio_uart_tx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the memory-mapped UART transmitter
// Holds the transmit FSM state type, the register offsets within the 8-byte
// window and the bit positions of the STATUS word.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam logic [2:0] OFF_TXDATA = 3'h0;
  localparam logic [2:0] OFF_STATUS = 3'h4;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_MSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous circular-buffer FIFO with occupancy count
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i, wdata_i     enqueue request and data (ignored when full)
//   pop_i, rdata_o      dequeue request (ignored when empty); rdata_o is the head
//   full_o, empty_o     occupancy flags, valid before the edge
//   count_o             number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE        = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Full/empty are pre-edge, so a push while full is dropped even if a pop
  // frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + ONE;
    if (do_push && !do_pop)      count_d = count_q + ONE;
    else if (do_pop && !do_push) count_d = count_q - ONE;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter on the CPU data bus
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   memAddress          CPU byte address; window is BASE_ADDR..BASE_ADDR+7
//   memWriteData        CPU store data
//   memWrite, byteMask  store strobe and byte-lane enables
//   memReadData         registered read data (STATUS at +4, 0 otherwise)
//   sel_q               registered hit flag for the top-level read mux
//   tx                  serial output, idles high
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddress,
  input  logic [31:0] memWriteData,
  input  logic        memWrite,
  input  logic [3:0]  byteMask,
  output logic [31:0] memReadData,
  output logic        sel_q,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  logic          hit, wr_txdata, wr_status, sel_d;
  logic [2:0]    offset;
  logic [31:0]   status, rdata_q, rdata_d;
  logic          ovf_q, ovf_d;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_end;
  logic          unused_bits;

  assign unused_bits = ^{memWriteData[31:8], byteMask[3:1], memAddress[1:0]};

  // Address bits [1:0] are ignored, so only bit 2 picks the register.
  assign hit       = (memAddress[31:3] == BASE_ADDR[31:3]);
  assign offset    = {memAddress[2], 2'b00};
  assign wr_txdata = hit && memWrite && byteMask[0] && (offset == OFF_TXDATA);
  assign wr_status = hit && memWrite && byteMask[0] && (offset == OFF_STATUS);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (wr_txdata),
    .wdata_i (memWriteData[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status = '0;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_BUSY]  = (state_q != TX_IDLE);
    status[STAT_OVF]   = ovf_q;
    status[STAT_CNT_MSB:STAT_CNT_LSB] = 5'(fifo_count);
  end

  assign sel_d   = hit && !memWrite;
  assign rdata_d = (sel_d && (offset == OFF_STATUS)) ? status : '0;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_txdata && fifo_full)                ovf_d = 1'b1;
    else if (wr_status && memWriteData[STAT_OVF]) ovf_d = 1'b0;
  end

  assign baud_end = (baud_q == BAUD_LAST);

  // tx is registered: each transition loads the level of the next bit
  // period, so a frame is exactly ten bit periods from the popping edge.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          tx_d     = 1'b0;
          baud_d   = '0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (baud_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            tx_d     = 1'b0;
            state_d  = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  assign memReadData = rdata_q;
  assign tx          = tx_q;

endmodule
